// File: rtl/s2p_word_deser_pkg.sv
// s2p_word_deser_pkg
//   Shared definitions for the serial-to-parallel word deserializer:
//   FSM state encoding, its width, the default word length and a helper
//   that sizes the bit counter.
package s2p_word_deser_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int st_width      = 2;

  typedef enum logic [st_width-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } st_e;

  // Counter must be able to hold the value WIDTH itself (saturated state).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/s2p_bit_cnt.sv
// s2p_bit_cnt
//   Bit-position counter for the deserializer.
//   Ports:
//     clk, rst_b   clock, asynchronous active-low reset
//     clr          force count to 0 (highest priority)
//     load_one     force count to 1 (bit 0 was just captured)
//     inc          advance by one, saturating at WIDTH
//     count        current bit position to be written next
//     last         count == WIDTH-1: the next captured bit completes the word
module s2p_bit_cnt
  import s2p_word_deser_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          load_one,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_r;

  // Count register: clear beats load-one beats increment; never passes WIDTH.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (load_one) begin
      count_r <= CNT_ONE;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign last  = (count_r == CNT_LAST);

endmodule

// File: rtl/s2p_word_deser.sv
// s2p_word_deser
//   Collects an LSB-first serial bit stream into WIDTH-bit words and hands
//   each complete word to a consumer with a valid/ready handshake.
//   Ports:
//     clk, rst_b    clock, asynchronous active-low reset
//     bit_in        serial data bit (LSB first)
//     bit_vld       bit_in valid this cycle
//     frame_start   with bit_vld: this bit is bit 0 of a new word
//     word_out      assembled word (unwritten bits of a partial word read 0)
//     word_vld      word_out holds a complete word
//     word_rdy      consumer accepts word_out
//     frame_err     one-cycle pulse: a frame restarted before the word completed
//     overrun       one-cycle pulse: a bit arrived while a word was held and was lost
//   All outputs come straight from flops.
module s2p_word_deser
  import s2p_word_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  st_e              state_r;
  st_e              state_nxt_s;
  logic [WIDTH-1:0] word_r;
  logic [WIDTH-1:0] word_nxt_s;
  logic [WIDTH-1:0] first_word_s;
  logic             word_vld_r;
  logic             vld_nxt_s;
  logic             frame_err_r;
  logic             ferr_nxt_s;
  logic             overrun_r;
  logic             ovr_nxt_s;
  logic             cnt_clr_s;
  logic             cnt_load_s;
  logic             cnt_inc_s;
  logic [CW-1:0]    cnt_s;
  logic             cnt_last_s;
  logic             start_s;
  logic             xfer_s;

  // Write bit b at position idx; the mux form avoids an index wider than the word.
  function automatic logic [WIDTH-1:0] put_bit(input logic [WIDTH-1:0] w,
                                               input logic [CW-1:0]    idx,
                                               input logic             b);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CW'(i)) begin
        r[i] = b;
      end else begin
        r[i] = w[i];
      end
    end
    return r;
  endfunction

  s2p_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr      (cnt_clr_s),
    .load_one (cnt_load_s),
    .inc      (cnt_inc_s),
    .count    (cnt_s),
    .last     (cnt_last_s)
  );

  assign start_s      = bit_vld & frame_start;
  assign xfer_s       = word_vld_r & word_rdy;   // uses the registered valid only
  // A new frame wipes stale bits: everything above bit 0 reads 0.
  assign first_word_s = {{(WIDTH-1){1'b0}}, bit_in};

  // Next-state, next-word, pulse and counter-control decode.
  always_comb begin
    state_nxt_s = state_r;
    word_nxt_s  = word_r;
    vld_nxt_s   = word_vld_r;
    ferr_nxt_s  = 1'b0;
    ovr_nxt_s   = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        vld_nxt_s = 1'b0;
        if (start_s) begin
          word_nxt_s  = first_word_s;
          cnt_load_s  = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          // Bits outside a frame are ignored silently.
          cnt_clr_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (start_s) begin
          // Restart: drop the partial word, this bit becomes bit 0.
          word_nxt_s = first_word_s;
          cnt_load_s = 1'b1;
          ferr_nxt_s = 1'b1;
        end else if (bit_vld) begin
          word_nxt_s = put_bit(word_r, cnt_s, bit_in);
          cnt_inc_s  = 1'b1;
          if (cnt_last_s) begin
            state_nxt_s = ST_HOLD;
            vld_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (xfer_s) begin
          vld_nxt_s = 1'b0;
          if (start_s) begin
            // Back-to-back: the word leaves and the next one starts together.
            word_nxt_s  = first_word_s;
            cnt_load_s  = 1'b1;
            state_nxt_s = ST_SHIFT;
          end else begin
            // A continuation bit cannot belong to any frame here: it is lost.
            cnt_clr_s   = 1'b1;
            state_nxt_s = ST_IDLE;
            ovr_nxt_s   = bit_vld;
          end
        end else begin
          ovr_nxt_s = bit_vld;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        vld_nxt_s   = 1'b0;
        cnt_clr_s   = 1'b1;
      end
    endcase
  end

  // State, word and output flops.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= ST_IDLE;
      word_r      <= {WIDTH{1'b0}};
      word_vld_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      word_r      <= word_nxt_s;
      word_vld_r  <= vld_nxt_s;
      frame_err_r <= ferr_nxt_s;
      overrun_r   <= ovr_nxt_s;
    end
  end

  assign word_out  = word_r;
  assign word_vld  = word_vld_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_s2p_word_deser.sv
// tb_s2p_word_deser
//   Self-checking bench: a queue-based model of the word assembly rules is
//   compared against the DUT on every falling edge; directed scenarios pin
//   literal expectations; a randomized phase exercises the rest.
module tb_s2p_word_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_vld = 1'b0;
  logic         frame_start = 1'b0;
  logic         word_rdy = 1'b0;
  logic [W-1:0] word_out;
  logic         word_vld;
  logic         frame_err;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  s2p_word_deser #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .bit_in      (bit_in),
    .bit_vld     (bit_vld),
    .frame_start (frame_start),
    .word_out    (word_out),
    .word_vld    (word_vld),
    .word_rdy    (word_rdy),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  // ---------------- reference model ----------------
  bit           part_q[$];
  bit           in_frame   = 1'b0;
  bit           held_valid = 1'b0;
  bit           zero_known = 1'b1;
  bit           exp_ferr   = 1'b0;
  bit           exp_ovr    = 1'b0;
  logic [W-1:0] held_word  = '0;

  int           ovr_seen = 0;
  int           ferr_seen = 0;
  logic [W-1:0] delivered_q[$];

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] r;
    r = '0;
    foreach (part_q[i]) r[i] = part_q[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each clock edge (or immediately on reset).
  initial begin
    forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) begin
        part_q.delete();
        in_frame   = 1'b0;
        held_valid = 1'b0;
        held_word  = '0;
        zero_known = 1'b1;
        exp_ferr   = 1'b0;
        exp_ovr    = 1'b0;
      end else begin
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (held_valid) begin
          if (word_rdy) begin
            held_valid = 1'b0;
            if (bit_vld && frame_start) begin
              part_q.delete();
              part_q.push_back(bit_in);
              in_frame   = 1'b1;
              zero_known = 1'b0;
            end else if (bit_vld) begin
              exp_ovr = 1'b1;
            end
          end else if (bit_vld) begin
            exp_ovr = 1'b1;
          end
        end else if (bit_vld) begin
          if (frame_start) begin
            if (in_frame) exp_ferr = 1'b1;
            part_q.delete();
            part_q.push_back(bit_in);
            in_frame   = 1'b1;
            zero_known = 1'b0;
          end else if (in_frame) begin
            part_q.push_back(bit_in);
          end
          if (in_frame && part_q.size() == W) begin
            held_word  = pack_bits();
            held_valid = 1'b1;
            part_q.delete();
            in_frame   = 1'b0;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("word_vld", 32'(word_vld), 32'(held_valid));
      check("frame_err", 32'(frame_err), 32'(exp_ferr));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      if (held_valid) check("word_out_held", 32'(word_out), 32'(held_word));
      else if (in_frame) check("word_out_part", 32'(word_out), 32'(pack_bits()));
      else if (zero_known) check("word_out_zero", 32'(word_out), 32'd0);
      if (overrun) ovr_seen++;
      if (frame_err) ferr_seen++;
      if (word_vld && word_rdy) delivered_q.push_back(word_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Apply inputs, then return 2 time units after the edge that consumed them.
  task automatic cyc(input logic bv, input logic fs, input logic b, input logic rdy);
    bit_vld     = bv;
    frame_start = fs;
    bit_in      = b;
    word_rdy    = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) cyc(1'b1, (i == 0), w[i], rdy);
  endtask

  // Serial two's complementer: copy up to and including the first 1, invert after.
  function automatic logic [W-1:0] comp_stream(input logic [W-1:0] v);
    logic [W-1:0] r;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < W; i++) begin
      r[i] = seen ? ~v[i] : v[i];
      if (v[i]) seen = 1'b1;
    end
    return r;
  endfunction

  initial begin
    logic [W-1:0] a5;
    a5 = 8'hA5;
    repeat (2) @(posedge clk);
    #2;
    check("reset_vld", 32'(word_vld), 32'd0);
    check("reset_word", 32'(word_out), 32'd0);
    rst_b = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);    // stray bit in IDLE: ignored
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 0xA5 with latency check
    for (int i = 0; i < W - 1; i++) cyc(1'b1, (i == 0), a5[i], 1'b1);
    check("a5_vld_before_last", 32'(word_vld), 32'd0);
    cyc(1'b1, 1'b0, a5[W-1], 1'b1);
    check("a5_vld", 32'(word_vld), 32'd1);
    check("a5_word", 32'(word_out), 32'hA5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("a5_idle", 32'(word_vld), 32'd0);

    // upstream complementer chained with 0x05
    send_word(comp_stream(8'h05), 1'b1);
    check("comp_word", 32'(word_out), 32'hFB);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // hold 0x3C while two bits arrive
    send_word(8'h3C, 1'b0);
    ovr_seen = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_word", 32'(word_out), 32'h3C);
    check("hold_vld", 32'(word_vld), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_released", 32'(word_vld), 32'd0);
    check("overrun_count", 32'(ovr_seen), 32'd2);

    // frame restart after three bits of 0xFF
    ferr_seen = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    send_word(8'h12, 1'b1);
    check("restart_word", 32'(word_out), 32'h12);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("frame_err_count", 32'(ferr_seen), 32'd1);

    // reset in the middle of a word
    ferr_seen = 0;
    ovr_seen  = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    bit_vld = 1'b0;
    frame_start = 1'b0;
    rst_b = 1'b0;
    #1;
    check("midreset_vld", 32'(word_vld), 32'd0);
    check("midreset_word", 32'(word_out), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;
    send_word(8'h81, 1'b1);
    check("post_reset_word", 32'(word_out), 32'h81);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_reset_pulses", 32'(ferr_seen + ovr_seen), 32'd0);

    // back-to-back words
    ovr_seen = 0;
    delivered_q.delete();
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b_count", 32'(delivered_q.size()), 32'd2);
    if (delivered_q.size() == 2) begin
      check("b2b_first", 32'(delivered_q[0]), 32'h11);
      check("b2b_second", 32'(delivered_q[1]), 32'h22);
    end else begin
      check("b2b_queue", 32'(delivered_q.size()), 32'd2);
    end
    check("b2b_overrun", 32'(ovr_seen), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        bit_vld = 1'b0;
        rst_b   = 1'b0;
        @(posedge clk);
        #2;
        rst_b = 1'b1;
      end else begin
        cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2p_word_deser.md
S2P_WORD_DESER -- requirements
Module: s2p_word_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bit_in  input  1  serial data bit, LSB first, from the upstream serial two's-complementer output.
REQ-005 SHALL have port bit_vld  input  1  bit_in is valid this cycle.
REQ-006 SHALL have port frame_start  input  1  qualified by bit_vld; marks bit 0 of a word.
REQ-007 SHALL have port word_out  output  WIDTH  assembled word.
REQ-008 SHALL have port word_vld  output  1  word_out holds a complete word.
REQ-009 SHALL have port word_rdy  input  1  consumer accepts word_out.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: frame restarted mid-word.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: bit dropped while a word was held.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-013 IDLE: bit_vld&frame_start -> capture bit_in as bit 0, count=1, go SHIFT; bit_vld without frame_start ignored, no pulse.
REQ-014 SHIFT: each bit_vld without frame_start -> store bit_in at position count, count+1; no bit_vld -> hold.
REQ-015 SHIFT: capture of bit WIDTH-1 -> go HOLD; word_vld high from the next cycle (1-cycle latency after last bit edge).
REQ-016 SHIFT: bit_vld&frame_start -> discard partial word, capture bit as new bit 0, count=1, stay SHIFT, pulse frame_err.
REQ-017 HOLD: word_out stable and word_vld high until word_vld&word_rdy sampled at an edge.
REQ-018 HOLD: transfer with no new bit -> IDLE, word_vld low next cycle.
REQ-019 HOLD: transfer in same cycle as bit_vld&frame_start -> new bit 0 captured, go SHIFT, no overrun.
REQ-020 HOLD: bit_vld with no transfer (or non-frame_start bit during transfer) -> bit dropped, overrun pulses one cycle.
REQ-021 word_out bits not yet written in current frame SHALL read 0; register cleared on new frame_start.
REQ-022 Counter SHALL be $clog2(WIDTH+1) bits, never exceeding WIDTH, no wrap.
REQ-023 word_vld SHALL NOT depend combinationally on word_rdy.

Reset
REQ-024 rst_b low SHALL immediately force state IDLE, count 0, word_out 0, word_vld 0, frame_err 0, overrun 0.
REQ-025 Reset mid-SHIFT or mid-HOLD SHALL discard partial/held word; no pulse on release.
REQ-026 First edge after rst_b rises SHALL behave as IDLE.

Structure
REQ-027 State enum, its width constant st_width, and DEFAULT_WIDTH SHALL live in shared package s2p_word_deser_pkg.
REQ-028 Bit counter SHALL be a sub-module s2p_bit_cnt (clear, load-1, increment, terminal-count output).
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 WIDTH=8: frame_start+bits of 0xA5 LSB-first on 8 consecutive cycles, word_rdy=1 -> word_out=0xA5, word_vld one cycle after 8th bit edge, then IDLE.
REQ-031 Chain upstream complementer with 0x05 LSB-first -> word_out=0xFB.
REQ-032 word_rdy=0 for 5 cycles after 0x3C completes, 2 bit_vld bits sent -> word_out stays 0x3C, overrun pulses twice, transfer on word_rdy=1.
REQ-033 frame_start after 3 bits of 0xFF, then 8 bits 0x12 -> frame_err one pulse, word_out=0x12.
REQ-034 rst_b low after 4 bits, then full 0x81 frame -> word_vld low during reset, word_out=0x81, no stale bits.
REQ-035 Back-to-back: transfer and frame_start of next word same cycle -> words 0x11,0x22 both delivered, no overrun.
